// File: rtl/csr_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : csr_write_queue
// Description : Two-lane-in / one-lane-out CSR write staging FIFO with a
//               pending-address hit. Optional read forwarding is compiled in
//               when CSR_WQ_FORWARD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb0_csr_we,
    input  logic [13:0] wb0_csr_addr,
    input  logic [31:0] wb0_csr_wdata,
    input  logic        wb0_is_llw_scw,
    input  logic        wb1_csr_we,
    input  logic [13:0] wb1_csr_addr,
    input  logic [31:0] wb1_csr_wdata,
    input  logic        wb1_is_llw_scw,
    output logic        wb_stall,
    input  logic        tlb_inst_se,
    output logic        csr_write_en,
    output logic [13:0] csr_write_addr,
    output logic [31:0] csr_write_data,
    output logic        is_llw_scw,
    input  logic [13:0] rd_query_addr,
    output logic        rd_hit,
    output logic        q_empty
`ifdef CSR_WQ_FORWARD_EN
    ,
    output logic        rd_fwd_valid,
    output logic [31:0] rd_fwd_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [13:0] addr_mem_q [DEPTH];
    logic [31:0] data_mem_q [DEPTH];
    logic        llw_mem_q  [DEPTH];

    logic [CNT_W-1:0] req_n_w;
    logic [CNT_W-1:0] free_n_w;
    logic             enq_w;
    logic             deq_w;
    logic [PTR_W-1:0] lane1_idx_w;
    logic [PTR_W-1:0] scan_idx_w;
    logic             hit_w;
`ifdef CSR_WQ_FORWARD_EN
    logic [31:0]      fwd_data_w;
`endif

    // Stall check ignores the concurrent dequeue so the decision never depends
    // on tlb_inst_se timing.
    always_comb begin
        req_n_w     = CNT_W'(wb0_csr_we) + CNT_W'(wb1_csr_we);
        free_n_w    = C_DEPTH - count_q;
        wb_stall    = (req_n_w > free_n_w);
        enq_w       = !wb_stall;
        deq_w       = (count_q != '0) && !tlb_inst_se;
        lane1_idx_w = tail_q + PTR_W'(wb0_csr_we);
        tail_d      = enq_w ? (tail_q + PTR_W'(req_n_w)) : tail_q;
        head_d      = deq_w ? (head_q + PTR_W'(1)) : head_q;
        count_d     = count_q + (enq_w ? req_n_w : '0) - CNT_W'(deq_w);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_w && wb0_csr_we) begin
            addr_mem_q[tail_q] <= wb0_csr_addr;
            data_mem_q[tail_q] <= wb0_csr_wdata;
            llw_mem_q[tail_q]  <= wb0_is_llw_scw;
        end
        if (enq_w && wb1_csr_we) begin
            addr_mem_q[lane1_idx_w] <= wb1_csr_addr;
            data_mem_q[lane1_idx_w] <= wb1_csr_wdata;
            llw_mem_q[lane1_idx_w]  <= wb1_is_llw_scw;
        end
    end

    always_comb begin
        csr_write_en   = deq_w;
        csr_write_addr = deq_w ? addr_mem_q[head_q] : 14'd0;
        csr_write_data = deq_w ? data_mem_q[head_q] : 32'd0;
        is_llw_scw     = deq_w ? llw_mem_q[head_q]  : 1'b0;
        q_empty        = (count_q == '0);
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_w      = 1'b0;
        scan_idx_w = head_q;
`ifdef CSR_WQ_FORWARD_EN
        fwd_data_w = 32'd0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx_w = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_mem_q[scan_idx_w] == rd_query_addr)) begin
                hit_w = 1'b1;
`ifdef CSR_WQ_FORWARD_EN
                fwd_data_w = data_mem_q[scan_idx_w];
`endif
            end
        end
    end

    assign rd_hit = hit_w;

`ifdef CSR_WQ_FORWARD_EN
    assign rd_fwd_valid = hit_w;
    assign rd_fwd_data  = fwd_data_w;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_write_queue
// Description : Directed self-checking bench for csr_write_queue (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb0_csr_we = 1'b0;
    logic [13:0] wb0_csr_addr = '0;
    logic [31:0] wb0_csr_wdata = '0;
    logic        wb0_is_llw_scw = 1'b0;
    logic        wb1_csr_we = 1'b0;
    logic [13:0] wb1_csr_addr = '0;
    logic [31:0] wb1_csr_wdata = '0;
    logic        wb1_is_llw_scw = 1'b0;
    logic        wb_stall;
    logic        tlb_inst_se = 1'b0;
    logic        csr_write_en;
    logic [13:0] csr_write_addr;
    logic [31:0] csr_write_data;
    logic        is_llw_scw;
    logic [13:0] rd_query_addr = '0;
    logic        rd_hit;
    logic        q_empty;
`ifdef CSR_WQ_FORWARD_EN
    logic        rd_fwd_valid;
    logic [31:0] rd_fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_write_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb0_csr_we     (wb0_csr_we),
        .wb0_csr_addr   (wb0_csr_addr),
        .wb0_csr_wdata  (wb0_csr_wdata),
        .wb0_is_llw_scw (wb0_is_llw_scw),
        .wb1_csr_we     (wb1_csr_we),
        .wb1_csr_addr   (wb1_csr_addr),
        .wb1_csr_wdata  (wb1_csr_wdata),
        .wb1_is_llw_scw (wb1_is_llw_scw),
        .wb_stall       (wb_stall),
        .tlb_inst_se    (tlb_inst_se),
        .csr_write_en   (csr_write_en),
        .csr_write_addr (csr_write_addr),
        .csr_write_data (csr_write_data),
        .is_llw_scw     (is_llw_scw),
        .rd_query_addr  (rd_query_addr),
        .rd_hit         (rd_hit),
        .q_empty        (q_empty)
`ifdef CSR_WQ_FORWARD_EN
        ,
        .rd_fwd_valid   (rd_fwd_valid),
        .rd_fwd_data    (rd_fwd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes_idle();
        wb0_csr_we = 1'b0; wb0_csr_addr = '0; wb0_csr_wdata = '0; wb0_is_llw_scw = 1'b0;
        wb1_csr_we = 1'b0; wb1_csr_addr = '0; wb1_csr_wdata = '0; wb1_is_llw_scw = 1'b0;
    endtask

    task automatic lane0(input logic [13:0] a, input logic [31:0] d);
        wb0_csr_we = 1'b1; wb0_csr_addr = a; wb0_csr_wdata = d; wb0_is_llw_scw = 1'b0;
    endtask

    task automatic lane1(input logic [13:0] a, input logic [31:0] d, input logic llw);
        wb1_csr_we = 1'b1; wb1_csr_addr = a; wb1_csr_wdata = d; wb1_is_llw_scw = llw;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        lanes_idle();
        lane0(14'h3, 32'h3);
        lane1(14'h4, 32'h4, 1'b1);
        tick();
        checks++; if (csr_write_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", csr_write_en); end
        checks++; if (csr_write_addr !== 14'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", csr_write_addr); end
        checks++; if (csr_write_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", csr_write_data); end
        checks++; if (is_llw_scw !== 1'b0) begin errors++; $display("FAIL rst_llw got=%b exp=0", is_llw_scw); end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", q_empty); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%b exp=0", rd_hit); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", wb_stall); end
        lanes_idle();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL rst_release_empty got=%b exp=1", q_empty); end
    endtask

    task automatic test_single();
        lane0(14'h006, 32'h1C00_0100);
        #1;
        checks++; if (csr_write_en !== 1'b0) begin errors++; $display("FAIL single_nobypass got=%b exp=0", csr_write_en); end
        tick();
        lanes_idle();
        #1;
        checks++; if (csr_write_en !== 1'b1) begin errors++; $display("FAIL single_en got=%b exp=1", csr_write_en); end
        checks++; if (csr_write_addr !== 14'h006) begin errors++; $display("FAIL single_addr got=%h exp=006", csr_write_addr); end
        checks++; if (csr_write_data !== 32'h1C00_0100) begin errors++; $display("FAIL single_data got=%h exp=1c000100", csr_write_data); end
        checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL single_nonempty got=%b exp=0", q_empty); end
        tick();
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", q_empty); end
        checks++; if (csr_write_en !== 1'b0) begin errors++; $display("FAIL single_idle_en got=%b exp=0", csr_write_en); end
    endtask

    task automatic test_dual_order();
        lane0(14'h000, 32'hA);
        lane1(14'h001, 32'hB, 1'b0);
        tick();
        lanes_idle();
        #1;
        checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== 14'h000 || csr_write_data !== 32'hA)
            begin errors++; $display("FAIL dual_first got=%b/%h/%h exp=1/000/a", csr_write_en, csr_write_addr, csr_write_data); end
        tick();
        checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== 14'h001 || csr_write_data !== 32'hB)
            begin errors++; $display("FAIL dual_second got=%b/%h/%h exp=1/001/b", csr_write_en, csr_write_addr, csr_write_data); end
        tick();
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL dual_empty got=%b exp=1", q_empty); end
    endtask

    task automatic test_full_stall();
        logic [13:0] exp_addr [4];
        exp_addr[0] = 14'h11; exp_addr[1] = 14'h12; exp_addr[2] = 14'h13; exp_addr[3] = 14'h14;
        tlb_inst_se = 1'b1;
        lane0(14'h10, 32'h10);
        lane1(14'h11, 32'h11, 1'b0);
        tick();
        lanes_idle();
        lane0(14'h12, 32'h12);
        tick();
        lanes_idle();
        lane0(14'h13, 32'h13);
        lane1(14'h14, 32'h14, 1'b0);
        #1;
        checks++; if (csr_write_en !== 1'b0) begin errors++; $display("FAIL full_tlb_hold got=%b exp=0", csr_write_en); end
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL full_stall3 got=%b exp=1", wb_stall); end
        tick();
        tlb_inst_se = 1'b0;
        #1;
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL full_stall_conservative got=%b exp=1", wb_stall); end
        checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== 14'h10)
            begin errors++; $display("FAIL full_drain_head got=%b/%h exp=1/010", csr_write_en, csr_write_addr); end
        tick();
        tlb_inst_se = 1'b1;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL full_accept got=%b exp=0", wb_stall); end
        tick();
        lanes_idle();
        lane0(14'h15, 32'h15);
        #1;
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL full_count4 got=%b exp=1", wb_stall); end
        lanes_idle();
        tlb_inst_se = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== exp_addr[i])
                begin errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", i, csr_write_en, csr_write_addr, exp_addr[i]); end
            tick();
        end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", q_empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i <= 10; i++) begin
            lanes_idle();
            if (i < 10) lane0(14'h020, 32'(i));
            #1;
            if (i > 0) begin
                checks++; if (csr_write_en !== 1'b1 || csr_write_data !== 32'(i - 1))
                    begin errors++; $display("FAIL wrap%0d got=%b/%h exp=1/%h", i - 1, csr_write_en, csr_write_data, i - 1); end
            end
            tick();
        end
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", q_empty); end
    endtask

    task automatic test_llbit_hit();
        rd_query_addr = 14'h060;
        lanes_idle();
        lane1(14'h060, 32'h1, 1'b1);
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL hit_lane_excluded got=%b exp=0", rd_hit); end
        tick();
        lanes_idle();
        tlb_inst_se = 1'b1;
        #1;
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL hit_queued got=%b exp=1", rd_hit); end
        tick();
        tlb_inst_se = 1'b0;
        #1;
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL hit_deq_cycle got=%b exp=1", rd_hit); end
        checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== 14'h060 || is_llw_scw !== 1'b1)
            begin errors++; $display("FAIL llw_strobe got=%b/%h/%b exp=1/060/1", csr_write_en, csr_write_addr, is_llw_scw); end
        tick();
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL hit_clear got=%b exp=0", rd_hit); end
        rd_query_addr = 14'h030;
        lane0(14'h030, 32'h1);
        lane1(14'h030, 32'h2, 1'b0);
        tlb_inst_se = 1'b1;
        tick();
        lanes_idle();
        #1;
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL hit_two got=%b exp=1", rd_hit); end
`ifdef CSR_WQ_FORWARD_EN
        checks++; if (rd_fwd_valid !== 1'b1 || rd_fwd_data !== 32'h2)
            begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/2", rd_fwd_valid, rd_fwd_data); end
`endif
        rd_query_addr = 14'h031;
        #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL hit_miss got=%b exp=0", rd_hit); end
        tlb_inst_se = 1'b0;
        tick();
        tick();
        checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL hit_drained got=%b exp=1", q_empty); end
    endtask

    task automatic test_reset_mid();
        tlb_inst_se = 1'b1;
        lane0(14'h040, 32'h40);
        lane1(14'h041, 32'h41, 1'b0);
        tick();
        lanes_idle();
        lane0(14'h042, 32'h42);
        tick();
        lanes_idle();
        tlb_inst_se = 1'b0;
        #1;
        checks++; if (csr_write_en !== 1'b1 || csr_write_addr !== 14'h040)
            begin errors++; $display("FAIL rmid_pre got=%b/%h exp=1/040", csr_write_en, csr_write_addr); end
        rst = 1'b0;
        #1;
        checks++; if (q_empty !== 1'b1 || csr_write_en !== 1'b0)
            begin errors++; $display("FAIL rmid_async got=%b/%b exp=1/0", q_empty, csr_write_en); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (csr_write_en !== 1'b0 || q_empty !== 1'b1)
                begin errors++; $display("FAIL rmid_post%0d got=%b/%b exp=0/1", i, csr_write_en, q_empty); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_full_stall();
        test_wrap();
        test_llbit_hit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_write_queue.md
# csr_write_queue

Write-side staging buffer between the dual-lane writeback stage and the single CSR write port of `csr`. It accepts up to two CSR write requests per cycle (lane 0 older than lane 1) and queues them in program order. It drains them one per cycle onto `csr_write_en/addr/data` and `is_llw_scw`. It exposes a pending-address hit so dispatch never reads a stale CSR.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `wb0_csr_we` in 1: lane 0 write request (older).
- `wb0_csr_addr` in 14: lane 0 CSR address.
- `wb0_csr_wdata` in 32: lane 0 write data.
- `wb0_is_llw_scw` in 1: lane 0 write is an LLBit update from `ll.w`/`sc.w`.
- `wb1_csr_we`, `wb1_csr_addr`, `wb1_csr_wdata`, `wb1_is_llw_scw` in 1/14/32/1: lane 1, same meanings (younger).
- `wb_stall` out 1: both lanes refused this cycle; writeback holds its requests.
- `tlb_inst_se` in 1: a TLB instruction owns the CSR write path this cycle; drain is paused.
- `csr_write_en` out 1: write strobe to `csr`.
- `csr_write_addr` out 14: address to `csr`.
- `csr_write_data` out 32: data to `csr`.
- `is_llw_scw` out 1: LLBit flag to `csr`.
- `rd_query_addr` in 14: CSR address dispatch is about to read.
- `rd_hit` out 1: a queued entry targets `rd_query_addr`.
- `q_empty` out 1: no entries queued; used to gate `ertn`, exception entry and `idle`.
- Present only with the macro: `rd_fwd_valid` out 1 and `rd_fwd_data` out 32.

## Operation
- Circular buffer with head pointer, tail pointer and count.
- Pointer width is log2(DEPTH). Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1, range 0 to DEPTH.
- Enqueue:
  - `req_n` = `wb0_csr_we` + `wb1_csr_we`.
  - `wb_stall` = (`req_n` > DEPTH − count). It is combinational and ignores any same-cycle dequeue (conservative).
  - When stalled, nothing is enqueued. Acceptance is all-or-nothing across both lanes.
  - When not stalled:
    - Lane 0 is written at tail, then lane 1 at tail+1 if lane 0 is valid, otherwise at tail.
    - Tail advances by `req_n`.
  - A lane with `we`=0 is ignored regardless of its address or data.
- Dequeue:
  - `csr_write_en` = (count ≠ 0) & !`tlb_inst_se`.
  - `csr_write_addr`, `csr_write_data` and `is_llw_scw` come combinationally from the head entry. They are 0 whenever `csr_write_en`=0.
  - On `csr_write_en`, head advances by 1. `csr` always accepts a strobed write.
- Count update: count_next = count + (accepted `req_n`) − dequeue. Enqueue and dequeue may happen in the same cycle.
- `rd_hit`: OR over all valid entries of (entry address == `rd_query_addr`). Current-cycle wb lanes are not included. Dispatch stalls the CSR read while `rd_hit`=1.
- `q_empty` = (count == 0).
- Reset: asynchronous clear of head, tail and count. Entry storage need not be cleared.

## Timing
- A write enqueued at edge N can strobe `csr` in cycle N+1 at the earliest. There is no empty-queue bypass.
- Back-to-back writes drain at 1 per cycle. A two-lane burst takes two drain cycles.
- `tlb_inst_se` high for k cycles delays the head by exactly k cycles. The queue keeps accepting until full.
- `rd_hit` deasserts in the cycle after the last matching entry is dequeued.
- Reset outputs:
  - `csr_write_en`=0, `csr_write_addr`=0, `csr_write_data`=0, `is_llw_scw`=0.
  - `wb_stall`=0 unless `req_n` > DEPTH.
  - `rd_hit`=0, `q_empty`=1, `rd_fwd_valid`=0, `rd_fwd_data`=0.
- Reset asserted mid-burst discards all queued writes immediately, independent of `clk`.

## Configuration
- `CSR_WQ_FORWARD_EN` defined:
  - `rd_fwd_valid` = `rd_hit`.
  - `rd_fwd_data` = write data of the youngest valid entry whose address matches `rd_query_addr`. It is 0 when there is no match.
  - Dispatch takes the forwarded value only for full-width-writable CSRs and stalls on `rd_hit` otherwise.
- Undefined: neither forwarding port exists and only `rd_hit` is provided.

## Test plan
- Single write, `DEPTH`=4:
  - Stimulus: lane 0 writes addr 0x006 (ERA), data 0x1C00_0100, at cycle 0.
  - Response: cycle 1 `csr_write_en`=1, addr 0x006, data 0x1C00_0100. Cycle 2 `q_empty`=1.
- Dual-lane ordering:
  - Stimulus: lane 0 writes 0x000 ← 0xA and lane 1 writes 0x001 ← 0xB in the same cycle.
  - Response: cycle 1 strobes 0x000/0xA, cycle 2 strobes 0x001/0xB.
- Full and stall:
  - Stimulus: with `tlb_inst_se`=1, fill 3 entries, then present a two-lane request.
  - Response: `wb_stall`=1 and no enqueue. Dropping `tlb_inst_se` drains the head. The next cycle accepts both lanes and count reaches 4.
- Wrap-around: 10 sequential single writes with data 0..9 drain in order 0..9 across pointer wrap.
- LLBit and hit:
  - Stimulus: lane 1 write with addr 0x060, `wb1_is_llw_scw`=1, while `rd_query_addr`=0x060.
  - Response: `rd_hit`=1 until the dequeue cycle, and `is_llw_scw`=1 on that strobe.
  - With `CSR_WQ_FORWARD_EN`: two queued writes to 0x030 (data 1 then 2) give `rd_fwd_data`=2.
- Reset mid-operation: with 3 entries queued, pulse `rst` low → `q_empty`=1 and `csr_write_en`=0 immediately, with no strobe after release.
